// File: rtl/vector_data_memory_if.sv
// Request/response bus between the vector load/store unit and the vector data memory.
// The master side issues requests and consumes responses; the slave side is the memory.
interface vector_data_memory_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LANES    = 4,
  parameter int STRIDE_W = 8
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [STRIDE_W-1:0]     req_stride;
  logic [LANES-1:0]        req_mask;
  logic [LANES*DATA_W-1:0] req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [LANES*DATA_W-1:0] rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/vector_data_memory.sv
// Byte-addressed little-endian vector data memory: one lane per cycle through a single
// word-wide storage port, with per-lane masking, strided addressing and error reporting.
module vector_data_memory #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 10020,
  parameter int LANES     = 4,
  parameter int STRIDE_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  vector_data_memory_if.slave bus
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int EXT_W  = ADDR_W + STRIDE_W + $clog2(LANES) + 1;
  localparam int MIDX_W = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [LANE_W-1:0]       lane;
  logic [LANES*DATA_W-1:0] rdata_q;
  logic                    err_q;

  logic                    lat_we;
  logic [ADDR_W-1:0]       lat_addr;
  logic [STRIDE_W-1:0]     lat_stride;
  logic [LANES-1:0]        lat_mask;
  logic [LANES*DATA_W-1:0] lat_wdata;
  logic                    lat_mis;

  logic [7:0]              mem [MEM_BYTES];

  logic                    accept;
  logic                    last_lane;
  logic [EXT_W-1:0]        cur_addr;
  logic                    cur_en;
  logic                    cur_in_range;
  logic                    wr_en;
  logic                    rd_en;
  logic [MIDX_W-1:0]       byte_idx [BYTES];
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       wr_word;

  function automatic logic misaligned(input logic [ADDR_W-1:0] a);
    return (BYTES > 1) && (a[OFF_W-1:0] != '0);
  endfunction

  // Extended width keeps a lane that runs past the top of the address space from aliasing low.
  function automatic logic [EXT_W-1:0] lane_address(input logic [ADDR_W-1:0]   a,
                                                    input logic [STRIDE_W-1:0] s,
                                                    input logic [LANE_W-1:0]   k);
    return EXT_W'(a) + EXT_W'(k) * EXT_W'(s) * EXT_W'(BYTES);
  endfunction

  function automatic logic lane_in_range(input logic [EXT_W-1:0] a);
    return (a + EXT_W'(BYTES)) <= EXT_W'(MEM_BYTES);
  endfunction

  assign accept       = bus.req_valid && (state == IDLE);
  assign last_lane    = (lane == LANE_W'(LANES - 1));
  assign cur_addr     = lane_address(lat_addr, lat_stride, lane);
  assign cur_en       = lat_mask[lane] && !lat_mis;
  assign cur_in_range = lane_in_range(cur_addr);
  assign wr_en        = (state == BUSY) && cur_en && cur_in_range && lat_we;
  assign rd_en        = (state == BUSY) && cur_en && cur_in_range && !lat_we;
  assign wr_word      = lat_wdata[lane*DATA_W +: DATA_W];

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < BYTES; b++) begin
      byte_idx[b]        = cur_addr[MIDX_W-1:0] + MIDX_W'(b);
      rd_word[8*b +: 8]  = mem[byte_idx[b]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = BUSY;
      BUSY:    if (last_lane)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Lane sequencing and response accumulation; cleared on acceptance so stores answer with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      lane    <= '0;
      rdata_q <= '0;
      err_q   <= misaligned(bus.req_addr);
    end else if (state == BUSY) begin
      lane <= last_lane ? '0 : lane + 1'b1;
      if (rd_en) begin
        rdata_q[lane*DATA_W +: DATA_W] <= rd_word;
      end
      if (cur_en && !cur_in_range) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= bus.req_we;
      lat_addr   <= bus.req_addr;
      lat_stride <= bus.req_stride;
      lat_mask   <= bus.req_mask;
      lat_wdata  <= bus.req_wdata;
      lat_mis    <= misaligned(bus.req_addr);
    end
  end

  // Storage is never reset; the write enable is gated by BUSY, which reset forces away.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        mem[byte_idx[b]] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_vector_data_memory.sv
// Bench for vector_data_memory: directed vector table, corner sequences (backpressure,
// reset mid-operation) and random requests checked against a byte-array reference model.
module tb_vector_data_memory;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 10020;
  localparam int LANES     = 4;
  localparam int STRIDE_W  = 8;
  localparam int BYTES     = DATA_W / 8;
  localparam int VW        = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vector_data_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .STRIDE_W(STRIDE_W)) bus ();

  vector_data_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .LANES(LANES), .STRIDE_W(STRIDE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [MEM_BYTES];

  typedef struct {
    string          name;
    bit             we;
    logic [31:0]    addr;
    logic [7:0]     stride;
    logic [3:0]     mask;
    logic [VW-1:0]  wdata;
    logic [VW-1:0]  exp_rdata;
    bit             exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit we, input logic [31:0] addr, input logic [7:0] stride,
                     input logic [3:0] mask, input logic [VW-1:0] wdata, input logic [VW-1:0] exp_rdata,
                     input bit exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.stride = stride; v.mask = mask;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  // Reference: lanes applied in order against a flat byte array, straight from the addressing rules.
  task automatic model_req(input bit we, input logic [31:0] addr, input logic [7:0] stride,
                           input logic [3:0] mask, input logic [VW-1:0] wdata,
                           output logic [VW-1:0] rdata, output logic err);
    longint a;
    rdata = '0;
    err   = 1'b0;
    if (addr % BYTES != 0) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < LANES; k++) begin
      a = longint'(addr) + longint'(k) * longint'(stride) * BYTES;
      if (!mask[k]) continue;
      if (a + BYTES > MEM_BYTES) begin
        err = 1'b1;
        continue;
      end
      for (int b = 0; b < BYTES; b++) begin
        if (we) model_mem[int'(a) + b] = wdata[k*DATA_W + 8*b +: 8];
        else    rdata[k*DATA_W + 8*b +: 8] = model_mem[int'(a) + b];
      end
    end
  endtask

  task automatic send(input bit we, input logic [31:0] addr, input logic [7:0] stride,
                      input logic [3:0] mask, input logic [VW-1:0] wdata);
    int n;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_stride = stride;
    bus.req_mask   = mask;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0d expected 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_req(input bit we, input logic [31:0] addr, input logic [7:0] stride,
                         input logic [3:0] mask, input logic [VW-1:0] wdata,
                         output logic [VW-1:0] rdata, output logic err);
    int lat;
    send(we, addr, stride, mask, wdata);
    wait_rsp(lat);
    check("latency", VW'(lat), VW'(LANES));
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    ack();
  endtask

  task automatic run_and_model(input string name, input bit we, input logic [31:0] addr,
                               input logic [7:0] stride, input logic [3:0] mask, input logic [VW-1:0] wdata);
    logic [VW-1:0] rd, mrd;
    logic          er, mer;
    model_req(we, addr, stride, mask, wdata, mrd, mer);
    run_req(we, addr, stride, mask, wdata, rd, er);
    check({name, "_rdata"}, rd, mrd);
    check({name, "_err"}, VW'(er), VW'(mer));
  endtask

  initial begin
    logic [VW-1:0] rd, mrd, wd, hold;
    logic          er, mer;
    logic [31:0]   addr;
    logic [7:0]    stride;
    int            lat, sel;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_stride = '0;
    bus.req_mask = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    add("st_unit",     1, 32'h10, 8'd1, 4'b1111, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, '0, 0);
    add("ld_unit",     0, 32'h10, 8'd1, 4'b1111, '0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0);
    add("st_w00",      1, 32'h00, 8'd0, 4'b0001, {96'h0, 32'hCAFE0000}, '0, 0);
    add("st_w20",      1, 32'h20, 8'd0, 4'b0001, {96'h0, 32'h0BAD0020}, '0, 0);
    add("st_w40",      1, 32'h40, 8'd0, 4'b0001, {96'h0, 32'h00C0FFEE}, '0, 0);
    add("ld_strided",  0, 32'h00, 8'd8, 4'b0101, '0, {32'h0, 32'h00C0FFEE, 32'h0, 32'hCAFE0000}, 0);
    add("st_stride0",  1, 32'h80, 8'd0, 4'b1111, {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1}, '0, 0);
    add("ld_stride0",  0, 32'h80, 8'd1, 4'b0001, '0, {96'h0, 32'hD4D4D4D4}, 0);
    add("st_bounds",   1, 32'd10016, 8'd1, 4'b0011, {64'h0, 32'h12345678, 32'hDEADBEEF}, '0, 1);
    add("ld_bounds",   0, 32'd10016, 8'd1, 4'b0011, '0, {96'h0, 32'hDEADBEEF}, 1);
    add("ld_misal",    0, 32'h02, 8'd1, 4'b1111, '0, '0, 1);
    add("st_misal",    1, 32'h12, 8'd1, 4'b1111, {4{32'hFFFFFFFF}}, '0, 1);
    add("ld_post_mis", 0, 32'h10, 8'd1, 4'b1111, '0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0);
    add("ld_mask0_oob",0, 32'd10020, 8'd1, 4'b0000, '0, '0, 0);
    add("ld_no_alias", 0, 32'hFFFFFFF0, 8'd4, 4'b0010, '0, '0, 1);

    #1;
    check("rst_rsp_valid", VW'(bus.rsp_valid), '0);
    check("rst_rsp_rdata", bus.rsp_rdata, '0);
    check("rst_rsp_err",   VW'(bus.rsp_err), '0);
    check("rst_req_ready", VW'(bus.req_ready), VW'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_req_ready", VW'(bus.req_ready), VW'(1));

    for (int i = 0; i < tbl.size(); i++) begin
      model_req(tbl[i].we, tbl[i].addr, tbl[i].stride, tbl[i].mask, tbl[i].wdata, mrd, mer);
      run_req(tbl[i].we, tbl[i].addr, tbl[i].stride, tbl[i].mask, tbl[i].wdata, rd, er);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
      check({tbl[i].name, "_err"}, VW'(er), VW'(tbl[i].exp_err));
    end
    check("byte_0x10", VW'(dut.mem[16]), VW'(8'h11));
    check("byte_0x14", VW'(dut.mem[20]), VW'(8'h22));

    // Fill all of storage so the model knows every byte before random traffic.
    for (int a = 0; a < MEM_BYTES; a += 16) begin
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_and_model("fill", 1'b1, 32'(a), 8'd1, 4'b1111, wd);
    end

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       addr = 32'($urandom_range(0, MEM_BYTES/4 - 1) * 4);
      else if (sel == 7) addr = 32'(MEM_BYTES - 4 * int'($urandom_range(1, 8)));
      else if (sel == 8) addr = 32'($urandom_range(0, MEM_BYTES - 1));
      else               addr = $urandom();
      stride = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_and_model("rand", 1'($urandom_range(0, 1)), addr, stride, 4'($urandom_range(0, 15)), wd);
    end

    // Backpressure: response must hold while a competing request is offered.
    model_req(1'b0, 32'd10016, 8'd1, 4'b0011, '0, mrd, mer);
    send(1'b0, 32'd10016, 8'd1, 4'b0011, '0);
    wait_rsp(lat);
    check("bp_latency", VW'(lat), VW'(LANES));
    bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_mask = 4'b1111; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", VW'(bus.rsp_valid), VW'(1));
      check("bp_rsp_rdata", bus.rsp_rdata, mrd);
      check("bp_rsp_err",   VW'(bus.rsp_err), VW'(mer));
      check("bp_req_ready", VW'(bus.req_ready), '0);
    end
    bus.req_valid = 1'b0;
    ack();
    check("bp_done_valid", VW'(bus.rsp_valid), '0);
    check("bp_done_ready", VW'(bus.req_ready), VW'(1));
    run_and_model("bp_after", 1'b0, 32'h20, 8'd1, 4'b1111, '0);

    // Reset while a response with live data is pending clears outputs without a clock edge.
    model_req(1'b0, 32'h10, 8'd1, 4'b1111, '0, mrd, mer);
    send(1'b0, 32'h10, 8'd1, 4'b1111, '0);
    wait_rsp(lat);
    hold = bus.rsp_rdata;
    check("rresp_rdata", hold, mrd);
    rst = 1'b1;
    #1;
    check("rresp_valid_clr", VW'(bus.rsp_valid), '0);
    check("rresp_rdata_clr", bus.rsp_rdata, '0);
    check("rresp_ready",     VW'(bus.req_ready), VW'(1));
    @(negedge clk);
    rst = 1'b0;

    // Reset after lane 1 of a store: lanes 0-1 land, lanes 2-3 keep old contents.
    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(1'b1, 32'h200, 8'd1, 4'b1111, wd);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rmid_valid_clr", VW'(bus.rsp_valid), '0);
    check("rmid_rdata_clr", bus.rsp_rdata, '0);
    check("rmid_err_clr",   VW'(bus.rsp_err), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_req(1'b1, 32'h200, 8'd1, 4'b0011, wd, mrd, mer);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rmid_no_rsp", VW'(bus.rsp_valid), '0);
      check("rmid_ready",  VW'(bus.req_ready), VW'(1));
    end
    run_and_model("rmid_load", 1'b0, 32'h200, 8'd1, 4'b1111, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
